ifetch_unit: RTL and testbench

//  Instruction-fetch stage of the MIPS CPU: holds the PC, fetches words from

---
 rtl/ifetch_unit_if.sv | 34 +++
 rtl/ifetch_unit.sv | 159 +++++++++++++++
 tb/tb_ifetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, redirect, decode handshake.
// master = fetch unit side, slave = memory/decode/branch side.
interface ifetch_unit_if #(
    parameter int IMM_W = 16
);
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_pc;
    logic [31:0]      id_inst;
    logic [IMM_W-1:0] id_imm16;
    logic             id_s_ext;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output id_valid, id_pc, id_inst, id_imm16, id_s_ext,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  id_valid, id_pc, id_inst, id_imm16, id_s_ext,
        output id_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, decode valid/ready, redirect flush.
// Ports: clk, rst_n (async low), bus (ifetch_unit_if.master).
// Option IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          IMM_W    = 16
) (
    input logic          clk,
    input logic          rst_n,
    ifetch_unit_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        vld_q, vld_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] inst_q, inst_d;
    logic        sext_q, sext_d;
    logic [31:0] rpc;

    // Word-align the redirect target.
    assign rpc = bus.redirect_pc & ~32'h3;

    // Logical-immediate opcodes (andi/ori/xori/lui) are zero-extended.
    function automatic logic sext_of(input logic [5:0] op);
        logic s;
        case (op)
            6'h0C, 6'h0D, 6'h0E, 6'h0F: s = 1'b0;
            default:                    s = 1'b1;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack && !bus.redirect) state_d = S_HOLD;
                else if (!bus.imem_ack && bus.redirect) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.imem_ack) state_d = S_FETCH;
            end
            S_HOLD: begin
                if (bus.redirect || bus.id_ready) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs; request drops combinationally with reset.
    always_comb begin
        bus.imem_req  = (state_q != S_HOLD) && rst_n;
        bus.imem_addr = pc_q;
        bus.id_valid  = vld_q;
        bus.id_pc     = ipc_q;
        bus.id_inst   = inst_q;
        bus.id_imm16  = inst_q[IMM_W-1:0];
        bus.id_s_ext  = sext_q;
    end

    // Datapath next values
    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        vld_d  = vld_q;
        ipc_d  = ipc_q;
        inst_d = inst_q;
        sext_d = sext_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        pc_d = rpc;
                    end else begin
                        inst_d = bus.imem_rdata;
                        sext_d = sext_of(bus.imem_rdata[31:26]);
                        ipc_d  = pc_q;
                        pc_d   = pc_q + 32'd4;
                        vld_d  = 1'b1;
                    end
                end else if (bus.redirect) begin
                    pend_d = rpc;
                end
            end
            S_DRAIN: begin
                // Outstanding word is stale; resume at the latest target.
                if (bus.imem_ack) pc_d = bus.redirect ? rpc : pend_q;
                else if (bus.redirect) pend_d = rpc;
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    vld_d = 1'b0;
                    pc_d  = rpc;
                end else if (bus.id_ready) begin
                    vld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
            vld_q  <= 1'b0;
            ipc_q  <= '0;
            inst_q <= '0;
            sext_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            vld_q  <= vld_d;
            ipc_q  <= ipc_d;
            inst_q <= inst_d;
            sext_q <= sext_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] fcnt_q, scnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            if (vld_q && bus.id_ready && !bus.redirect)
                fcnt_q <= fcnt_q + 32'd1;
            if (bus.imem_req && !bus.imem_ack)
                scnt_q <= scnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fcnt_q;
    assign perf_stall_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch cadence, imm/sext, stall, redirect,
// drain, PC wrap and async reset on a second instance.
module tb_ifetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ifetch_unit_if #(.IMM_W(16)) bus ();
    ifetch_unit_if #(.IMM_W(16)) w ();

`ifdef IFETCH_PERF_EN
    logic [31:0] pf, ps, wf, ws;
`endif

    ifetch_unit #(
        .RESET_PC(32'h0040_0000),
        .IMM_W(16)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt(pf),
        .perf_stall_cnt(ps)
`endif
    );

    ifetch_unit #(
        .RESET_PC(32'hFFFF_FFFC),
        .IMM_W(16)
    ) u_wrap (
        .clk(clk),
        .rst_n(rst2_n),
        .bus(w.master)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt(wf),
        .perf_stall_cnt(ws)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; acks at once, returns in HOLD.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] data);
        check({tag, ".req"}, 32'(bus.imem_req), 32'd1);
        check({tag, ".addr"}, bus.imem_addr, addr);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        check({tag, ".vld"}, 32'(bus.id_valid), 32'd1);
        check({tag, ".pc"}, bus.id_pc, addr);
        check({tag, ".inst"}, bus.id_inst, data);
        check({tag, ".reqlo"}, 32'(bus.imem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b1;
        w.imem_ack = 1'b0;
        w.imem_rdata = '0;
        w.redirect = 1'b0;
        w.redirect_pc = '0;
        w.id_ready = 1'b1;

        @(negedge clk);
        check("rst.req", 32'(bus.imem_req), 32'd0);
        check("rst.addr", bus.imem_addr, 32'h0040_0000);
        check("rst.vld", 32'(bus.id_valid), 32'd0);
        check("rst.pc", bus.id_pc, 32'd0);
        check("rst.inst", bus.id_inst, 32'd0);
        check("rst.imm", 32'(bus.id_imm16), 32'd0);
        check("rst.sext", 32'(bus.id_s_ext), 32'd0);

        // 1: back-to-back fetches
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        fetch("t1a", 32'h0040_0000, 32'h2401_0001);
        @(negedge clk);
        check("t1a.gap", 32'(bus.id_valid), 32'd0);
        fetch("t1b", 32'h0040_0004, 32'h2402_0002);
        @(negedge clk);
        fetch("t1c", 32'h0040_0008, 32'h2403_0003);
        @(negedge clk);
        check("t1.vld0", 32'(bus.id_valid), 32'd0);
`ifdef IFETCH_PERF_EN
        check("perf.fetch", pf, 32'd3);
        check("perf.stall", ps, 32'd0);
`endif

        // 2: immediate and extend select
        fetch("t2ori", 32'h0040_000C, 32'h3421_8000);
        check("t2ori.imm", 32'(bus.id_imm16), 32'h8000);
        check("t2ori.sext", 32'(bus.id_s_ext), 32'd0);
        @(negedge clk);
        fetch("t2addi", 32'h0040_0010, 32'h2021_8000);
        check("t2addi.imm", 32'(bus.id_imm16), 32'h8000);
        check("t2addi.sext", 32'(bus.id_s_ext), 32'd1);
        @(negedge clk);
        fetch("t2lui", 32'h0040_0014, 32'h3C01_FFFF);
        check("t2lui.imm", 32'(bus.id_imm16), 32'hFFFF);
        check("t2lui.sext", 32'(bus.id_s_ext), 32'd0);
        @(negedge clk);

        // 3: decode stall
        fetch("t3", 32'h0040_0018, 32'h8C22_0004);
        bus.id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3.vld", 32'(bus.id_valid), 32'd1);
            check("t3.inst", bus.id_inst, 32'h8C22_0004);
            check("t3.req", 32'(bus.imem_req), 32'd0);
        end
        bus.id_ready = 1'b1;
        @(negedge clk);
        check("t3.next", bus.imem_addr, 32'h0040_001C);
        check("t3.nreq", 32'(bus.imem_req), 32'd1);
        check("t3.nvld", 32'(bus.id_valid), 32'd0);

        // 4a: redirect with delayed ack -> drain
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0040_0100;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("t4a.hold", bus.imem_addr, 32'h0040_001C);
        check("t4a.req", 32'(bus.imem_req), 32'd1);
        check("t4a.vld", 32'(bus.id_valid), 32'd0);
        @(negedge clk);
        check("t4a.vld2", 32'(bus.id_valid), 32'd0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("t4a.drop", 32'(bus.id_valid), 32'd0);
        check("t4a.addr", bus.imem_addr, 32'h0040_0100);
        fetch("t4a.f", 32'h0040_0100, 32'h2404_0004);
        @(negedge clk);

        // 4b: second redirect in drain wins
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0040_0180;
        @(negedge clk);
        bus.redirect_pc = 32'h0040_0200;
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("t4b.drop", 32'(bus.id_valid), 32'd0);
        check("t4b.addr", bus.imem_addr, 32'h0040_0200);

        // 5: redirect beats id_ready in hold; low bits forced 0
        fetch("t5", 32'h0040_0200, 32'h2405_0005);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0040_0103;
        @(negedge clk);
        bus.redirect = 1'b0;
        check("t5.vld", 32'(bus.id_valid), 32'd0);
        check("t5.req", 32'(bus.imem_req), 32'd1);
        check("t5.addr", bus.imem_addr, 32'h0040_0100);

        // ack and redirect together in fetch: data dropped
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0040_0040;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        check("t5b.vld", 32'(bus.id_valid), 32'd0);
        check("t5b.addr", bus.imem_addr, 32'h0040_0040);

        // 6: PC wrap and async reset mid-wait
        rst2_n = 1'b1;
        #1;
        check("t6.addr0", w.imem_addr, 32'hFFFF_FFFC);
        check("t6.req0", 32'(w.imem_req), 32'd1);
        w.imem_ack = 1'b1;
        w.imem_rdata = 32'h1111_1111;
        @(negedge clk);
        w.imem_ack = 1'b0;
        check("t6.vld", 32'(w.id_valid), 32'd1);
        check("t6.pc", w.id_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t6.wrap", w.imem_addr, 32'h0000_0000);
        check("t6.req1", 32'(w.imem_req), 32'd1);
        #2;
        rst2_n = 1'b0;
        #1;
        check("t6.rreq", 32'(w.imem_req), 32'd0);
        check("t6.rpc", w.imem_addr, 32'hFFFF_FFFC);
        check("t6.rvld", 32'(w.id_valid), 32'd0);
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        check("t6.again", w.imem_addr, 32'hFFFF_FFFC);
        check("t6.areq", 32'(w.imem_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
